inst_decode: RTL and testbench

RV32I instruction decoder for the rysy core's decode stage: splits a 32-bit instruction word into register indices, function fields, a sign-extended immediate and control signals. Decode is combinational; all outputs are registered on the single clock. The result feeds the register-file read stage and execute in the following cycle.

---
 rtl/inst_decode.sv | 188 ++++++++++++++++++
 tb/tb_inst_decode.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/inst_decode.sv
// RV32I decode stage: splits an instruction word into register indices, function
// fields, a sign-extended immediate and control strobes, registered for the next stage.
module inst_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [5:0]  fmt,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Shared R / OP-IMM mapping; alt is inst[30], which only OP-IMM may not use for SUB.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
    case (f3)
      3'b000:  arith_op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = 4'd2;
      3'b010:  arith_op = 4'd3;
      3'b011:  arith_op = 4'd4;
      3'b100:  arith_op = 4'd5;
      3'b101:  arith_op = alt ? 4'd7 : 4'd6;
      3'b110:  arith_op = 4'd8;
      default: arith_op = 4'd9;
    endcase
  endfunction

  logic [6:0]  opcode_d, opcode_q;
  logic [4:0]  rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;
  logic [2:0]  funct3_d, funct3_q;
  logic [6:0]  funct7_d, funct7_q;
  logic [31:0] imm_d, imm_q;
  logic [5:0]  fmt_d, fmt_q;
  logic [3:0]  alu_op_d, alu_op_q;
  logic        reg_we_d, reg_we_q, mem_rd_d, mem_rd_q, mem_wr_d, mem_wr_q;
  logic        branch_d, branch_q, jump_d, jump_q, illegal_d, illegal_q;

  always_comb begin
    opcode_d  = inst[6:0];
    rd_d      = inst[11:7];
    rs1_d     = inst[19:15];
    rs2_d     = inst[24:20];
    funct3_d  = inst[14:12];
    funct7_d  = inst[31:25];
    imm_d     = '0;
    fmt_d     = '0;
    alu_op_d  = ALU_ADD;
    reg_we_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    branch_d  = 1'b0;
    jump_d    = 1'b0;
    illegal_d = 1'b0;
    case (inst[6:0])
      OP_R: begin
        fmt_d    = FMT_R;
        reg_we_d = 1'b1;
        alu_op_d = arith_op(inst[14:12], inst[30], 1'b1);
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt_d    = FMT_I;
        rs2_d    = '0;
        imm_d    = {{20{inst[31]}}, inst[31:20]};
        reg_we_d = 1'b1;
        mem_rd_d = (inst[6:0] == OP_LOAD);
        jump_d   = (inst[6:0] == OP_JALR);
        if (inst[6:0] == OP_IMM) alu_op_d = arith_op(inst[14:12], inst[30], 1'b0);
      end
      OP_STORE: begin
        fmt_d    = FMT_S;
        rd_d     = '0;
        imm_d    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        mem_wr_d = 1'b1;
      end
      OP_BRANCH: begin
        fmt_d    = FMT_B;
        rd_d     = '0;
        imm_d    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        branch_d = 1'b1;
        alu_op_d = ALU_SUB;
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d    = FMT_U;
        rs1_d    = '0;
        rs2_d    = '0;
        imm_d    = {inst[31:12], 12'b0};
        reg_we_d = 1'b1;
        if (inst[6:0] == OP_LUI) alu_op_d = ALU_PASSB;
      end
      OP_JAL: begin
        fmt_d    = FMT_J;
        rs1_d    = '0;
        rs2_d    = '0;
        imm_d    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        reg_we_d = 1'b1;
        jump_d   = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // ---- decode register: one-cycle latency, held while en is low ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      imm_q     <= '0;
      fmt_q     <= '0;
      alu_op_q  <= '0;
      reg_we_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      branch_q  <= 1'b0;
      jump_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (en) begin
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      alu_op_q  <= alu_op_d;
      reg_we_q  <= reg_we_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      branch_q  <= branch_d;
      jump_q    <= jump_d;
      illegal_q <= illegal_d;
    end
  end

  assign opcode  = opcode_q;
  assign rd      = rd_q;
  assign rs1     = rs1_q;
  assign rs2     = rs2_q;
  assign funct3  = funct3_q;
  assign funct7  = funct7_q;
  assign imm     = imm_q;
  assign fmt     = fmt_q;
  assign alu_op  = alu_op_q;
  assign reg_we  = reg_we_q;
  assign mem_rd  = mem_rd_q;
  assign mem_wr  = mem_wr_q;
  assign branch  = branch_q;
  assign jump    = jump_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_inst_decode.sv
// Directed-vector bench for inst_decode with hand-computed expected decodes.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] inst = '0;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [5:0]  fmt;
  logic [3:0]  alu_op;
  logic        reg_we, mem_rd, mem_wr, branch, jump, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  inst_decode dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inst(inst),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .fmt(fmt),
    .alu_op(alu_op), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control bundle order: {reg_we, mem_rd, mem_wr, branch, jump, illegal}
  function automatic logic [31:0] ctl();
    return {26'd0, reg_we, mem_rd, mem_wr, branch, jump, illegal};
  endfunction

  task automatic step(input logic [31:0] i, input logic e);
    @(negedge clk);
    inst = i;
    en   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fmt"}, 32'(fmt), 32'd0);
    chk({tag, "_imm"}, imm, 32'd0);
    chk({tag, "_ctl"}, ctl(), 32'd0);
    chk({tag, "_regs"}, {17'd0, rd, rs1, rs2}, 32'd0);
    chk({tag, "_fn"}, {12'd0, opcode, funct3, funct7, alu_op}, 32'd0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    step(32'h002081b3, 1'b1);
    chk("add_fmt", 32'(fmt), 32'h01);
    chk("add_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
    chk("add_fn", {22'd0, funct3, funct7}, 32'd0);
    chk("add_alu", 32'(alu_op), 32'd0);
    chk("add_ctl", ctl(), 32'b100000);
    chk("add_imm", imm, 32'd0);
    chk("add_opc", 32'(opcode), 32'h33);

    // ADDI x2,x1,0x54
    step(32'h05408113, 1'b1);
    chk("addi_fmt", 32'(fmt), 32'h02);
    chk("addi_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd2, 5'd1, 5'd0});
    chk("addi_imm", imm, 32'h00000054);
    chk("addi_alu", 32'(alu_op), 32'd0);
    chk("addi_ctl", ctl(), 32'b100000);

    // LUI x1,0x23
    step(32'h000230B7, 1'b1);
    chk("lui_fmt", 32'(fmt), 32'h10);
    chk("lui_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd1, 5'd0, 5'd0});
    chk("lui_imm", imm, 32'h00023000);
    chk("lui_alu", 32'(alu_op), 32'd10);

    // BNE x2,x1,-8
    step(32'hfe111ce3, 1'b1);
    chk("bne_fmt", 32'(fmt), 32'h08);
    chk("bne_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd0, 5'd2, 5'd1});
    chk("bne_f3", 32'(funct3), 32'd1);
    chk("bne_imm", imm, 32'hFFFFFFF8);
    chk("bne_ctl", ctl(), 32'b000100);
    chk("bne_alu", 32'(alu_op), 32'd1);

    // JAL x4,-8
    step(32'hff9ff26f, 1'b1);
    chk("jal_fmt", 32'(fmt), 32'h20);
    chk("jal_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd4, 5'd0, 5'd0});
    chk("jal_imm", imm, 32'hFFFFFFF8);
    chk("jal_ctl", ctl(), 32'b100010);

    // SW x2,8(x1)
    step(32'h0020A423, 1'b1);
    chk("sw_fmt", 32'(fmt), 32'h04);
    chk("sw_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd0, 5'd1, 5'd2});
    chk("sw_imm", imm, 32'h00000008);
    chk("sw_ctl", ctl(), 32'b001000);

    // LW x5,-4(x1)
    step(32'hFFC0A283, 1'b1);
    chk("lw_fmt", 32'(fmt), 32'h02);
    chk("lw_imm", imm, 32'hFFFFFFFC);
    chk("lw_ctl", ctl(), 32'b110000);
    chk("lw_rs2", 32'(rs2), 32'd0);

    // SRAI x1,x1,3
    step(32'h4030D093, 1'b1);
    chk("srai_alu", 32'(alu_op), 32'd7);
    chk("srai_imm", imm, 32'h00000403);

    // JALR x1,0(x2)
    step(32'h000100E7, 1'b1);
    chk("jalr_fmt", 32'(fmt), 32'h02);
    chk("jalr_ctl", ctl(), 32'b100010);
    chk("jalr_rs1", 32'(rs1), 32'd2);

    // SUB x4,x2,x1
    step(32'h40110233, 1'b1);
    chk("sub_alu", 32'(alu_op), 32'd1);
    chk("sub_f7", 32'(funct7), 32'h20);
    chk("sub_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd4, 5'd2, 5'd1});

    // Hold: new instruction presented with en low must not change anything
    step(32'h05408113, 1'b0);
    chk("hold_alu", 32'(alu_op), 32'd1);
    chk("hold_f7", 32'(funct7), 32'h20);
    chk("hold_regs", {17'd0, rd, rs1, rs2}, {17'd0, 5'd4, 5'd2, 5'd1});

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h002081b3, 1'b0);
    chk_all_zero("post_rst");

    // Unrecognised opcode
    step(32'hFFFFFFFF, 1'b1);
    chk("ill_ctl", ctl(), 32'b000001);
    chk("ill_fmt", 32'(fmt), 32'd0);
    chk("ill_imm", imm, 32'd0);
    chk("ill_alu", 32'(alu_op), 32'd0);

    // Back-to-back decodes after illegal
    step(32'h000230B7, 1'b1);
    chk("b2b_ill", 32'(illegal), 32'd0);
    chk("b2b_alu", 32'(alu_op), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
